// File: rtl/m5_clk_rst_seq_if.sv
// Control/status bundle of the M5 clock-enable generator and reset sequencer.
// master drives requests and modes; slave is the sequencer itself.
interface m5_clk_rst_seq_if #(
    parameter int NUM_CE  = 2,
    parameter int NUM_RST = 4
);
    logic [NUM_RST-1:0] rst_req_i;
    logic               pause_i;
    logic               turbo_i;
    logic [NUM_CE-1:0]  ce_o;
    logic               sys_reset_n_o;
    logic               por_n_o;
    logic               busy_o;

    modport master (
        output rst_req_i, pause_i, turbo_i,
        input  ce_o, sys_reset_n_o, por_n_o, busy_o
    );

    modport slave (
        input  rst_req_i, pause_i, turbo_i,
        output ce_o, sys_reset_n_o, por_n_o, busy_o
    );
endinterface

// File: rtl/m5_clk_rst_seq.sv
// Power-of-two clock-enable generator with turbo/pause, plus a reset sequencer
// that stretches synchronised requests and releases them aligned to the CE phase.
module m5_clk_rst_seq #(
    parameter int                  NUM_CE   = 2,
    parameter logic [4*NUM_CE-1:0] CE_DIV   = {4'd3, 4'd2},
    parameter int                  MAX_DIV  = 3,
    parameter int                  NUM_RST  = 4,
    parameter int                  HOLD_CYC = 16,
    parameter int                  REF_CE   = 1
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    m5_clk_rst_seq_if.slave io
);
    localparam int            HW      = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC);

    typedef enum logic [1:0] {POR, HOLD, ALIGN, RUN} state_t;

    state_t             r_state;
    logic [MAX_DIV-1:0] r_div_q;
    logic [NUM_CE-1:0]  r_ce;
    logic [NUM_CE-1:0]  w_ce_nxt;
    logic [NUM_RST-1:0] r_req_s1;
    logic [NUM_RST-1:0] r_req_s2;
    logic [HW-1:0]      r_hold_cnt;
    logic               r_sys_rst_n;
    logic               r_por_n;
    logic               r_busy;
    logic               w_any_req;
    logic               w_align_ok;

    // Channel fires when the low d_i bits of the divider are zero; d_i==0 gives an empty mask.
    for (genvar g = 0; g < NUM_CE; g++) begin : g_ce
        logic [3:0]       w_div_cfg;
        logic [3:0]       w_div_eff;
        logic [MAX_DIV:0] w_mask;

        assign w_div_cfg   = CE_DIV[4*g +: 4];
        assign w_div_eff   = (io.turbo_i && (w_div_cfg != 4'd0)) ? w_div_cfg - 4'd1 : w_div_cfg;
        assign w_mask      = ((MAX_DIV+1)'(1) << w_div_eff) - (MAX_DIV+1)'(1);
        assign w_ce_nxt[g] = ~io.pause_i & ((r_div_q & w_mask[MAX_DIV-1:0]) == '0);
    end

    assign w_any_req  = |r_req_s2;
    assign w_align_ok = (r_div_q == '0) && !io.pause_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_div_q  <= '0;
            r_ce     <= '0;
            r_req_s1 <= '0;
            r_req_s2 <= '0;
        end else begin
            if (!io.pause_i) begin
                r_div_q <= r_div_q + 1'b1;
            end
            r_ce     <= w_ce_nxt;
            r_req_s1 <= io.rst_req_i;
            r_req_s2 <= r_req_s1;
        end
    end

    // ALIGN->RUN coincides with div_q==0, so every enable pulses in the release clk.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= POR;
            r_hold_cnt  <= '0;
            r_sys_rst_n <= 1'b0;
            r_por_n     <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                POR: begin
                    r_state    <= HOLD;
                    r_hold_cnt <= HOLD_LD;
                end
                HOLD: begin
                    if (w_any_req) begin
                        r_hold_cnt <= HOLD_LD;
                    end else if (r_hold_cnt == '0) begin
                        r_state <= ALIGN;
                    end else if (r_ce[REF_CE]) begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                ALIGN: begin
                    if (w_any_req) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= HOLD_LD;
                    end else if (w_align_ok) begin
                        r_state     <= RUN;
                        r_sys_rst_n <= 1'b1;
                        r_por_n     <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_any_req) begin
                        r_state     <= HOLD;
                        r_hold_cnt  <= HOLD_LD;
                        r_sys_rst_n <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= POR;
                end
            endcase
        end
    end

    assign io.ce_o          = r_ce;
    assign io.sys_reset_n_o = r_sys_rst_n;
    assign io.por_n_o       = r_por_n;
    assign io.busy_o        = r_busy;
endmodule

// File: tb/tb_m5_clk_rst_seq.sv
// Bench for m5_clk_rst_seq: directed stimulus, expected reset releases queued
// and checked by a separate monitor, plus direct enable-pattern checks.
module tb_m5_clk_rst_seq;
    typedef struct {
        int lo;
        int hi;
        int tmin;
        int tmax;
    } rel_t;

    logic clk_i     = 1'b0;
    logic reset_n_i = 1'b0;
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    rel_t exp_q[$];

    m5_clk_rst_seq_if #(.NUM_CE(2), .NUM_RST(4)) dif ();
    m5_clk_rst_seq_if #(.NUM_CE(2), .NUM_RST(4)) dif2 ();

    m5_clk_rst_seq #(
        .NUM_CE(2), .CE_DIV(8'h32), .MAX_DIV(3), .NUM_RST(4), .HOLD_CYC(16), .REF_CE(1)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .io(dif.slave)
    );

    // Second instance: a zero-divisor channel and a zero-length stretch.
    m5_clk_rst_seq #(
        .NUM_CE(2), .CE_DIV(8'h10), .MAX_DIV(3), .NUM_RST(4), .HOLD_CYC(0), .REF_CE(1)
    ) dut2 (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .io(dif2.slave)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic pulse_req(input int idx, input int h);
        dif.rst_req_i[idx] = 1'b1;
        step(h);
        dif.rst_req_i[idx] = 1'b0;
    endtask

    task automatic wait_release(input string nm, input int budget);
        int n = 0;
        while (dif.sys_reset_n_o !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        chk({nm, "_released"}, dif.sys_reset_n_o, 1);
    endtask

    task automatic push_rel(input int lo, input int hi, input int tmin, input int tmax);
        rel_t r;
        r.lo = lo; r.hi = hi; r.tmin = tmin; r.tmax = tmax;
        exp_q.push_back(r);
    endtask

    // Monitor: counts ce_o[1] ticks while held low and scores each release.
    logic prev_sys = 1'b0;
    int   ticks    = 0;
    always @(negedge clk_i) begin
        rel_t e;
        if (!reset_n_i) begin
            prev_sys = 1'b0;
            ticks    = 0;
        end else begin
            if (!dif.sys_reset_n_o && prev_sys) ticks = 0;
            if (!dif.sys_reset_n_o && dif.ce_o[1]) ticks++;
            if (dif.sys_reset_n_o && !prev_sys) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_release actual=cyc %0d expected=none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk_rng("rel_cyc", cyc, e.lo, e.hi);
                    chk_rng("rel_ticks", ticks, e.tmin, e.tmax);
                    chk("rel_ce", dif.ce_o, 2'b11);
                    chk("rel_por", dif.por_n_o, 1);
                    chk("rel_busy", dif.busy_o, 0);
                end
            end
            prev_sys = dif.sys_reset_n_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c;
        logic all_low;
        dif.rst_req_i  = '0; dif.pause_i  = 1'b0; dif.turbo_i  = 1'b0;
        dif2.rst_req_i = '0; dif2.pause_i = 1'b0; dif2.turbo_i = 1'b0;

        // reset values
        step(3);
        chk("rst_ce", dif.ce_o, 0);
        chk("rst_sys", dif.sys_reset_n_o, 0);
        chk("rst_por", dif.por_n_o, 0);
        chk("rst_busy", dif.busy_o, 1);
        chk("rst_ce2", dif2.ce_o, 0);
        chk("rst_sys2", dif2.sys_reset_n_o, 0);

        // 1) release with no requests
        push_rel(129, 145, 16, 16);
        reset_n_i = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step(1);
            chk("t1_ce", dif.ce_o, {((n-1) % 8 == 0), ((n-1) % 4 == 0)});
            chk("t1_ce2", dif2.ce_o, {((n-1) % 2 == 0), 1'b1});
            if (n == 8)  chk("t1_sys2_low", dif2.sys_reset_n_o, 0);
            if (n == 9)  chk("t1_sys2_rise", dif2.sys_reset_n_o, 1);
            if (n == 16) chk("t1_por_low", dif.por_n_o, 0);
        end
        wait_release("t1", 200);
        chk("t1_por", dif.por_n_o, 1);
        chk("t1_busy", dif.busy_o, 0);

        // 2) single-clk request pulse in RUN
        step(5);
        c = cyc;
        push_rel(c + 131, c + 138, 16, 16);
        pulse_req(2, 1);
        step(2);
        chk("t2_low_by3", dif.sys_reset_n_o, 0);
        chk("t2_por_kept", dif.por_n_o, 1);
        chk("t2_busy", dif.busy_o, 1);
        wait_release("t2", 200);
        chk("t2_por_after", dif.por_n_o, 1);

        // 3) long request held 500 clk
        step(3);
        c = cyc;
        push_rel(c + 630, c + 637, 16, 1000);
        dif.rst_req_i[0] = 1'b1;
        all_low = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step(1);
            if (i >= 2 && dif.sys_reset_n_o !== 1'b0) all_low = 1'b0;
        end
        dif.rst_req_i[0] = 1'b0;
        chk("t3_low_during", all_low, 1);
        wait_release("t3", 300);

        // 4) turbo on, then off
        step(3);
        dif.turbo_i = 1'b1; dif2.turbo_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1);
            chk("t4_turbo_ce", dif.ce_o, {((cyc-1) % 4 == 0), ((cyc-1) % 2 == 0)});
            chk("t4_turbo_ce2", dif2.ce_o, 2'b11);
        end
        chk("t4_sys_kept", dif.sys_reset_n_o, 1);
        dif.turbo_i = 1'b0; dif2.turbo_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            chk("t4_norm_ce", dif.ce_o, {((cyc-1) % 8 == 0), ((cyc-1) % 4 == 0)});
            chk("t4_norm_ce2", dif2.ce_o, {((cyc-1) % 2 == 0), 1'b1});
        end

        // 5) pause 40 clk mid-HOLD: release shifts by exactly 40, still 16 ticks
        step(2);
        c = cyc;
        push_rel(c + 171, c + 178, 16, 16);
        pulse_req(1, 1);
        step(38);
        dif.pause_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            chk("t5_ce_paused", dif.ce_o, 0);
        end
        chk("t5_sys_held", dif.sys_reset_n_o, 0);
        dif.pause_i = 1'b0;
        wait_release("t5", 300);

        // pause in RUN only gates the enables
        step(2);
        dif.pause_i = 1'b1;
        step(5);
        chk("run_pause_ce", dif.ce_o, 0);
        chk("run_pause_sys", dif.sys_reset_n_o, 1);
        chk("run_pause_busy", dif.busy_o, 0);
        dif.pause_i = 1'b0;

        // 6) async reset mid-HOLD
        step(3);
        pulse_req(3, 1);
        step(30);
        #2 reset_n_i = 1'b0;
        #1;
        chk("t6_async_ce", dif.ce_o, 0);
        chk("t6_async_sys", dif.sys_reset_n_o, 0);
        chk("t6_async_por", dif.por_n_o, 0);
        chk("t6_async_busy", dif.busy_o, 1);
        step(2);
        push_rel(129, 145, 16, 16);
        reset_n_i = 1'b1;
        step(1);
        chk("t6_first_ce", dif.ce_o, 2'b11);
        chk("t6_por_low", dif.por_n_o, 0);
        step(60);
        chk("t6_por_still_low", dif.por_n_o, 0);
        chk("t6_busy", dif.busy_o, 1);
        wait_release("t6", 200);
        chk("t6_por_high", dif.por_n_o, 1);

        step(3);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
